// File: rtl/col_idct_if.sv
// col_idct_if: stream bundle for the column inverse DCT.
// Input side carries one column of coefficients with valid/ready; output side carries
// the eight saturated samples, valid/ready, and the block column index / last marker.
// Optional feature: COL_IDCT_SATFLAG_EN adds the per-sample clamp flags o_sat.
interface col_idct_if #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 8
);

  // Input vector handshake
  logic                    i_valid;
  logic                    i_ready;
  logic signed [IN_W-1:0]  i_coef [8];

  // Output vector handshake
  logic                    o_valid;
  logic                    o_ready;
  logic signed [OUT_W-1:0] o_data [8];
  logic [2:0]              o_col_idx;
  logic                    o_last;
`ifdef COL_IDCT_SATFLAG_EN
  logic [7:0]              o_sat;
`endif

`ifdef COL_IDCT_SATFLAG_EN
  // Transform block side
  modport slave (
    input  i_valid, i_coef, o_ready,
    output i_ready, o_valid, o_data, o_col_idx, o_last, o_sat
  );

  // Producer/consumer side
  modport master (
    output i_valid, i_coef, o_ready,
    input  i_ready, o_valid, o_data, o_col_idx, o_last, o_sat
  );
`else
  // Transform block side
  modport slave (
    input  i_valid, i_coef, o_ready,
    output i_ready, o_valid, o_data, o_col_idx, o_last
  );

  // Producer/consumer side
  modport master (
    output i_valid, i_coef, o_ready,
    input  i_ready, o_valid, o_data, o_col_idx, o_last
  );
`endif

endinterface : col_idct_if

// File: rtl/col_idct.sv
// col_idct: 8-point 1-D inverse DCT over one column of signed coefficients.
//   x_n = sat((128*X0 + sum_k X_k*M[n][k] + 512) >>> 10), bit-exact, no early truncation.
// Pipeline: S1 registers the input, S2 forms even/odd butterfly sums at ACC_W,
// S3 combines, rounds, saturates into the output registers. One global enable
// (downstream not stalling) advances every stage, so throughput is one vector per cycle.
// ACC_W must be >= IN_W+12 so the widest sum cannot overflow.
// Optional feature: define COL_IDCT_SATFLAG_EN to add bus.o_sat (one clamp flag per sample).
module col_idct #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 8,
  parameter int ACC_W = 24
) (
  input  logic      i_clk,
  input  logic      i_rst,
  col_idct_if.slave bus
);

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [IN_W-1:0]  coef_t;
  typedef logic signed [OUT_W-1:0] samp_t;

  // Basis magnitudes round(256*cos(k*pi/16)); the DC weight is 128 = 256*cos(pi/4)/sqrt2 scaled.
  localparam acc_t K_DC  = acc_t'(128);
  localparam acc_t K_C1  = acc_t'(251);
  localparam acc_t K_C2  = acc_t'(237);
  localparam acc_t K_C3  = acc_t'(213);
  localparam acc_t K_C4  = acc_t'(181);
  localparam acc_t K_C5  = acc_t'(142);
  localparam acc_t K_C6  = acc_t'(98);
  localparam acc_t K_C7  = acc_t'(50);
  localparam acc_t K_RND = acc_t'(512);
  localparam int   SHIFT = 10;

  localparam acc_t SAT_MAX = acc_t'((2 ** (OUT_W - 1)) - 1);
  localparam acc_t SAT_MIN = acc_t'(-(2 ** (OUT_W - 1)));

  // ---------------------------------------------------------------------------
  // Global enable: the whole pipe moves unless the output holds a stalled vector.
  // ---------------------------------------------------------------------------
  logic en;
  logic o_valid_q, o_valid_d;

  assign en          = !o_valid_q || bus.o_ready;
  assign bus.i_ready = en;

  // ---------------------------------------------------------------------------
  // Stage 1: input capture
  // ---------------------------------------------------------------------------
  logic  s1_valid_q, s1_valid_d;
  coef_t s1_coef_q [8];
  coef_t s1_coef_d [8];

  // Stage 1 next state: take the incoming vector whenever the pipe advances.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    s1_valid_d = s1_valid_q;
    s1_coef_d  = s1_coef_q;
    if (en) begin
      s1_valid_d = bus.i_valid;
      s1_coef_d  = bus.i_coef;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: even/odd butterfly partial sums at full accumulator width
  // ---------------------------------------------------------------------------
  acc_t x [8];

  // Sign-extend the registered coefficients to accumulator width before any product.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      x[k] = acc_t'(s1_coef_q[k]);
    end
  end

  // Shared even-half products; x_n and x_(7-n) reuse the same even and odd terms.
  acc_t p_dc, p_x4c4, p_x2c2, p_x2c6, p_x6c2, p_x6c6;

  // Even-part products of the DC, X2, X4 and X6 coefficients.
  always_comb begin
    p_dc   = x[0] * K_DC;
    p_x4c4 = x[4] * K_C4;
    p_x2c2 = x[2] * K_C2;
    p_x2c6 = x[2] * K_C6;
    p_x6c2 = x[6] * K_C2;
    p_x6c6 = x[6] * K_C6;
  end

  logic s2_valid_q, s2_valid_d;
  acc_t s2_even_q [4];
  acc_t s2_even_d [4];
  acc_t s2_odd_q  [4];
  acc_t s2_odd_d  [4];

  // Stage 2 next state: even sums E_n and odd sums O_n for n = 0..3.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_even_d  = s2_even_q;
    s2_odd_d   = s2_odd_q;
    if (en) begin
      s2_valid_d   = s1_valid_q;

      s2_even_d[0] = p_dc + p_x4c4 + p_x2c2 + p_x6c6;
      s2_even_d[1] = p_dc - p_x4c4 + p_x2c6 - p_x6c2;
      s2_even_d[2] = p_dc - p_x4c4 - p_x2c6 + p_x6c2;
      s2_even_d[3] = p_dc + p_x4c4 - p_x2c2 - p_x6c6;

      s2_odd_d[0]  =  x[1] * K_C1 + x[3] * K_C3 + x[5] * K_C5 + x[7] * K_C7;
      s2_odd_d[1]  =  x[1] * K_C3 - x[3] * K_C7 - x[5] * K_C1 - x[7] * K_C5;
      s2_odd_d[2]  =  x[1] * K_C5 - x[3] * K_C1 + x[5] * K_C7 + x[7] * K_C3;
      s2_odd_d[3]  =  x[1] * K_C7 - x[3] * K_C5 + x[5] * K_C3 - x[7] * K_C1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: combine, round, floor-shift, saturate
  // ---------------------------------------------------------------------------
  acc_t sum [8];

  // Butterfly combine with the rounding constant folded in: x_n = E+O, x_(7-n) = E-O.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      sum[n]     = s2_even_q[n] + s2_odd_q[n] + K_RND;
      sum[7 - n] = s2_even_q[n] - s2_odd_q[n] + K_RND;
    end
  end

  samp_t data_q [8];
  samp_t data_d [8];
  logic  [7:0] clamp_flag;

  // Output data next state: arithmetic shift (floor) then clamp to the sample range.
  always_comb begin
    data_d     = data_q;
    clamp_flag = '0;
    for (int n = 0; n < 8; n++) begin
      acc_t shifted;
      shifted = sum[n] >>> SHIFT;
      if (shifted > SAT_MAX) begin
        clamp_flag[n] = 1'b1;
        if (en) data_d[n] = samp_t'(SAT_MAX);
      end else if (shifted < SAT_MIN) begin
        clamp_flag[n] = 1'b1;
        if (en) data_d[n] = samp_t'(SAT_MIN);
      end else begin
        if (en) data_d[n] = samp_t'(shifted);
      end
    end
  end

  // Output valid follows stage 2 when the pipe advances, otherwise holds.
  always_comb begin
    o_valid_d = o_valid_q;
    if (en) o_valid_d = s2_valid_q;
  end

  // ---------------------------------------------------------------------------
  // Column counter: counts output transfers, wraps every 8 columns.
  // ---------------------------------------------------------------------------
  logic [2:0] col_q, col_d;

  // Advance only on an accepted output; bubbles and stalls leave it alone.
  always_comb begin
    col_d = col_q;
    if (o_valid_q && bus.o_ready) col_d = col_q + 3'd1;
  end

`ifdef COL_IDCT_SATFLAG_EN
  logic [7:0] sat_q, sat_d;

  // Clamp flags travel with the output data and hold during a stall.
  always_comb begin
    sat_d = sat_q;
    if (en) sat_d = clamp_flag;
  end
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Control and output registers: synchronous reset drops in-flight vectors and clears outputs.
  always_ff @(posedge i_clk) begin
    // NOTE: clocked state uses non-blocking assignments; combinational blocks use blocking ones.
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      o_valid_q  <= 1'b0;
      col_q      <= 3'd0;
      data_q     <= '{default: '0};
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      o_valid_q  <= o_valid_d;
      col_q      <= col_d;
      data_q     <= data_d;
    end
  end

`ifdef COL_IDCT_SATFLAG_EN
  // Clamp flag register: cleared by reset like the output data.
  always_ff @(posedge i_clk) begin
    if (i_rst) sat_q <= '0;
    else       sat_q <= sat_d;
  end
`endif

  // Pipeline data registers for stages 1 and 2.
  always_ff @(posedge i_clk) begin
    // NOTE: these carry no reset; their contents only matter while the matching valid bit is set.
    s1_coef_q <= s1_coef_d;
    s2_even_q <= s2_even_d;
    s2_odd_q  <= s2_odd_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.o_valid   = o_valid_q;
  assign bus.o_data    = data_q;
  assign bus.o_col_idx = col_q;
  assign bus.o_last    = o_valid_q && (col_q == 3'd7);
`ifdef COL_IDCT_SATFLAG_EN
  assign bus.o_sat     = sat_q;
`else
  // The clamp flags are only consumed by the optional flag port.
  logic unused_clamp;
  assign unused_clamp = ^clamp_flag;
`endif

endmodule : col_idct

// File: tb/tb_col_idct.sv
// tb_col_idct: self-checking bench for col_idct.
// A formula-level model (8x8 matrix built from the cosine sign rule, plain integer sums)
// predicts every output vector; one monitor compares each valid output against it in order.
// Directed vectors add hand-computed literal expectations that also pin the model.
module tb_col_idct;

  localparam int IN_W  = 12;
  localparam int OUT_W = 8;
  localparam int ACC_W = 24;

  logic i_clk = 1'b0;
  logic i_rst;

  always #5 i_clk = ~i_clk;

  col_idct_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  col_idct #(.IN_W(IN_W), .OUT_W(OUT_W), .ACC_W(ACC_W)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_cmp  = 0;
  int n_fail = 0;
  int n_xfer = 0;
  int exp_col = 0;

  typedef struct packed {
    logic [7:0][7:0] d;
    logic [7:0]      sat;
  } exp_t;

  exp_t exp_q [$];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int c_mag(input int i);
    case (i)
      1: return 251;
      2: return 237;
      3: return 213;
      4: return 181;
      5: return 142;
      6: return 98;
      7: return 50;
      default: return 0;
    endcase
  endfunction

  function automatic int m_coef(input int n, input int k);
    int m;
    if (k == 0) return 128;
    m = ((2 * n + 1) * k) % 32;
    if (m > 16) m = 32 - m;
    if (m == 8) return 0;
    if (m < 8)  return c_mag(m);
    return -c_mag(16 - m);
  endfunction

  function automatic exp_t idct_model(input int x[8]);
    exp_t r;
    int   acc;
    int   y;
    r = '0;
    for (int n = 0; n < 8; n++) begin
      acc = 512;
      for (int k = 0; k < 8; k++) acc += x[k] * m_coef(n, k);
      y = acc >>> 10;
      if (y > 127) begin
        y = 127;
        r.sat[n] = 1'b1;
      end else if (y < -128) begin
        y = -128;
        r.sat[n] = 1'b1;
      end
      r.d[n] = 8'(y);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: scoreboard push on accept, compare on every valid output
  // ---------------------------------------------------------------------------
  initial begin
    logic            stalled_prev;
    logic [7:0][7:0] held;
    logic [7:0][7:0] cur;
    exp_t            e;
    int              cx [8];
    stalled_prev = 1'b0;
    held         = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        exp_q.delete();
        exp_col      = 0;
        stalled_prev = 1'b0;
      end else begin
        check("i_ready_rule", bus.i_ready, !bus.o_valid || bus.o_ready);
        check("o_col_idx", bus.o_col_idx, exp_col);
        check("o_last", bus.o_last, bus.o_valid && (exp_col == 7));
        if (bus.o_valid) begin
          for (int n = 0; n < 8; n++) cur[n] = bus.o_data[n];
          if (stalled_prev) check("stall_hold", cur, held);
          if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            e = exp_q[0];
            for (int n = 0; n < 8; n++)
              check($sformatf("o_data%0d", n), bus.o_data[n], $signed(e.d[n]));
`ifdef COL_IDCT_SATFLAG_EN
            check("o_sat", bus.o_sat, e.sat);
`endif
            if (bus.o_ready) begin
              void'(exp_q.pop_front());
              exp_col = (exp_col + 1) % 8;
              n_xfer++;
            end
          end
          stalled_prev = !bus.o_ready;
          held         = cur;
        end else begin
          stalled_prev = 1'b0;
        end
        if (bus.i_valid && bus.i_ready) begin
          for (int k = 0; k < 8; k++) cx[k] = int'(bus.i_coef[k]);
          exp_q.push_back(idct_model(cx));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive_vec(input int x[8]);
    for (int k = 0; k < 8; k++) bus.i_coef[k] = IN_W'(x[k]);
  endtask

  // One vector into an idle pipe with o_ready=1; checks the 3-cycle latency and
  // returns the output observed in the first valid cycle.
  task automatic send_single(input int x[8], input string tag,
                             output logic [7:0][7:0] d, output logic [7:0] s);
    @(posedge i_clk); #1;
    bus.o_ready = 1'b1;
    bus.i_valid = 1'b1;
    drive_vec(x);
    @(posedge i_clk); #1;
    bus.i_valid = 1'b0;
    @(negedge i_clk); check({tag, "_lat1"}, bus.o_valid, 0);
    @(negedge i_clk); check({tag, "_lat2"}, bus.o_valid, 0);
    @(negedge i_clk); check({tag, "_lat3"}, bus.o_valid, 1);
    for (int n = 0; n < 8; n++) d[n] = bus.o_data[n];
`ifdef COL_IDCT_SATFLAG_EN
    s = bus.o_sat;
`else
    s = '0;
`endif
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int              zv   [8];
    int              xv   [8];
    int              lit  [8];
    int              vec  [20][8];
    int              vecb [8];
    logic [7:0][7:0] d;
    logic [7:0]      s;
    exp_t            mm;
    int              idx, cyc, acc, xfer0;
    int              nout, nc, first_nc;
    logic            started, gap;

    i_rst       = 1'b1;
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.i_coef[k] = '0;
      zv[k]         = 0;
    end
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;

    // Reset state
    @(negedge i_clk);
    check("rst_o_valid", bus.o_valid, 0);
    check("rst_i_ready", bus.i_ready, 1);
    check("rst_col_idx", bus.o_col_idx, 0);
    check("rst_o_last", bus.o_last, 0);
    for (int n = 0; n < 8; n++) check($sformatf("rst_o_data%0d", n), bus.o_data[n], 0);
`ifdef COL_IDCT_SATFLAG_EN
    check("rst_o_sat", bus.o_sat, 0);
`endif

    // All-zero coefficients
    send_single(zv, "zero", d, s);
    check("zero_col_idx", bus.o_col_idx, 0);
    for (int n = 0; n < 8; n++) check($sformatf("zero_x%0d", n), $signed(d[n]), 0);
`ifdef COL_IDCT_SATFLAG_EN
    check("zero_sat", s, 0);
`endif

    // X0 = 64 -> every sample 8
    xv = zv; xv[0] = 64;
    send_single(xv, "dc64", d, s);
    for (int n = 0; n < 8; n++) check($sformatf("dc64_x%0d", n), $signed(d[n]), 8);

    // X0 = 2047 -> every sample clamps high
    xv = zv; xv[0] = 2047;
    send_single(xv, "dcmax", d, s);
    for (int n = 0; n < 8; n++) check($sformatf("dcmax_x%0d", n), $signed(d[n]), 127);
`ifdef COL_IDCT_SATFLAG_EN
    check("dcmax_sat", s, 8'hFF);
`endif

    // X0 = -2048 -> every sample clamps low
    xv = zv; xv[0] = -2048;
    send_single(xv, "dcmin", d, s);
    for (int n = 0; n < 8; n++) check($sformatf("dcmin_x%0d", n), $signed(d[n]), -128);
`ifdef COL_IDCT_SATFLAG_EN
    check("dcmin_sat", s, 8'hFF);
`endif

    // X1 = 100 -> hand-computed floor((100*M[n][1] + 512) / 1024)
    xv = zv; xv[1] = 100;
    lit = '{25, 21, 14, 5, -5, -14, -21, -25};
    mm = idct_model(xv);
    for (int n = 0; n < 8; n++) check($sformatf("model_x1_x%0d", n), $signed(mm.d[n]), lit[n]);
    send_single(xv, "ac1", d, s);
    for (int n = 0; n < 8; n++) check($sformatf("ac1_x%0d", n), $signed(d[n]), lit[n]);

    // Pin the model on a mixed vector: X2=40, X5=-60 gives x0 = floor((9480-8520+512)/1024) = 1
    xv = zv; xv[2] = 40; xv[5] = -60;
    mm = idct_model(xv);
    check("model_mix_x0", $signed(mm.d[0]), 1);

    // 20 random vectors with pseudo-random back-pressure
    for (int i = 0; i < 20; i++)
      for (int k = 0; k < 8; k++)
        vec[i][k] = (int'($urandom_range(0, 4095)) - 2048) >>> $urandom_range(0, 4);
    xfer0 = n_xfer;
    idx   = 0;
    cyc   = 0;
    @(posedge i_clk); #1;
    while (idx < 20 && cyc < 500) begin
      bus.o_ready = 1'($urandom_range(0, 1));
      bus.i_valid = 1'b1;
      drive_vec(vec[idx]);
      @(negedge i_clk);
      acc = int'(bus.i_ready);
      @(posedge i_clk); #1;
      if (acc != 0) idx++;
      cyc++;
    end
    bus.i_valid = 1'b0;
    check("stream_sent", idx, 20);
    while (exp_q.size() > 0 && cyc < 1000) begin
      bus.o_ready = 1'($urandom_range(0, 1));
      @(posedge i_clk); #1;
      cyc++;
    end
    bus.o_ready = 1'b1;
    @(negedge i_clk);
    check("stream_drained", exp_q.size(), 0);
    check("stream_xfers", n_xfer - xfer0, 20);

    // 16 back-to-back vectors from a fresh reset so the block counter starts at 0
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst    = 1'b0;
    nout     = 0;
    nc       = 0;
    first_nc = 0;
    started  = 1'b0;
    gap      = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          for (int k = 0; k < 8; k++) vecb[k] = (i * 37 + k * 101) % 400 - 200;
          bus.i_valid = 1'b1;
          drive_vec(vecb);
          @(posedge i_clk); #1;
        end
        bus.i_valid = 1'b0;
      end
      begin
        while (nout < 16 && nc < 40) begin
          @(negedge i_clk);
          nc++;
          if (bus.o_valid) begin
            if (!started) first_nc = nc;
            started = 1'b1;
            nout++;
            check($sformatf("b2b_last_%0d", nout), bus.o_last, (nout == 8) || (nout == 16));
          end else if (started) begin
            gap = 1'b1;
          end
        end
      end
    join
    check("b2b_first_latency", first_nc, 4);
    check("b2b_count", nout, 16);
    check("b2b_no_gap", gap, 0);
    @(negedge i_clk);
    check("b2b_col_wrap", bus.o_col_idx, 0);

    // Reset with three vectors in flight (output stalled so none transfers)
    send_single(vec[0], "pre_rst", d, s);
    @(posedge i_clk); #1;
    bus.o_ready = 1'b0;
    for (int i = 1; i < 4; i++) begin
      bus.i_valid = 1'b1;
      drive_vec(vec[i]);
      @(posedge i_clk); #1;
    end
    bus.i_valid = 1'b0;
    i_rst       = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("midrst_o_valid", bus.o_valid, 0);
    check("midrst_col_idx", bus.o_col_idx, 0);
    check("midrst_o_last", bus.o_last, 0);
    send_single(vec[5], "post_rst", d, s);
    check("post_rst_col_idx", bus.o_col_idx, 0);
    mm = idct_model(vec[5]);
    for (int n = 0; n < 8; n++)
      check($sformatf("post_rst_x%0d", n), $signed(d[n]), $signed(mm.d[n]));

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("final_idle", bus.o_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_col_idct
